sys_byte_memory: RTL and testbench

- Byte-wide system memory that sits directly downstream of the direct-mapped processor cache.
- Serves the cache's 4-byte line-fill bursts and its 4-byte write bursts over the 8-bit system bus (sysaddress / sysdata / sysrw / sysstrobe).
- Contains the backing byte array plus a small burst-sequencing FSM.
- Read timing matches the cache fill: first byte is valid for the cache to sample two edges after the edge that captured sysstrobe.

---
 rtl/sys_bus_pkg.sv | 26 ++
 rtl/sys_byte_ram.sv | 45 ++++
 rtl/sys_byte_memory.sv | 157 +++++++++++++++
 tb/tb_sys_byte_memory.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_bus_pkg
// Description : Shared definitions for the 8-bit system bus between the
//               direct-mapped cache and the byte-wide system memory.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_bus_pkg;

    // Default geometry of the system memory
    localparam int c_ADDR_W_DEFAULT    = 16;
    localparam int c_BURST_LEN_DEFAULT = 4;

    // sysrw encoding shared with the cache
    localparam logic c_SYS_RD = 1'b1;
    localparam logic c_SYS_WR = 1'b0;

    // Burst sequencer states
    typedef logic [1:0] sys_state_t;
    localparam sys_state_t c_ST_IDLE  = 2'd0;
    localparam sys_state_t c_ST_WAIT  = 2'd1;
    localparam sys_state_t c_ST_READ  = 2'd2;
    localparam sys_state_t c_ST_WRITE = 2'd3;

endpackage : sys_bus_pkg
`default_nettype wire

// File: rtl/sys_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : sys_byte_ram
// Description : Single-port synchronous byte array. Writes land on the rising
//               edge when i_we is high; reads are registered when i_re is high
//               and the read register holds otherwise. Only the read register
//               is cleared by rst; the array contents survive reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_byte_ram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [0:(1<<ADDR_W)-1];
    logic [7:0] r_rdata;

    // Array write port; deliberately not gated by reset so a beat landing on
    // the reset edge still completes
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read data, holds its value between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 8'h00;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sys_byte_ram
`default_nettype wire

// File: rtl/sys_byte_memory.sv
`default_nettype none
// ============================================================================
// Module      : sys_byte_memory
// Description : Byte-wide system memory serving aligned BURST_LEN-byte read
//               and write bursts from the cache over the 8-bit system bus.
//               A strobe captured in IDLE latches the line base and direction;
//               beats then walk base+0 .. base+BURST_LEN-1, wrapping inside
//               the line. Strobes outside IDLE are ignored.
//               Optional macro SYS_BYTE_MEMORY_STATS_EN adds completed-burst
//               counters rd_burst_cnt / wr_burst_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_byte_memory
    import sys_bus_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W_DEFAULT,
    parameter int BURST_LEN   = c_BURST_LEN_DEFAULT,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] sysaddress,
    input  logic              sysrw,
    input  logic              sysstrobe,
    input  logic [7:0]        sysdata_in,
    output logic [7:0]        sysdata_out,
    output logic              sysvalid,
    output logic              sysbusy
`ifdef SYS_BYTE_MEMORY_STATS_EN
    ,
    output logic [15:0]       rd_burst_cnt,
    output logic [15:0]       wr_burst_cnt
`endif
);

    localparam int c_BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int c_WAIT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int c_WAIT_LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [ADDR_W-1:0]   c_LINE_MASK = ADDR_W'(BURST_LEN - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_END  = c_WAIT_W'(c_WAIT_LAST);

    sys_state_t          r_state;
    logic [ADDR_W-1:0]   r_base;
    logic                r_rw;
    logic [c_BEAT_W-1:0] r_beat;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_valid;
    logic                r_busy;

    logic [ADDR_W-1:0]   w_addr;
    logic                w_last_beat;
    logic                w_ram_we;
    logic                w_ram_re;
    sys_state_t          w_data_state;

    // Beat address: the low field is replaced, never added, so it cannot carry
    assign w_addr       = r_base | (ADDR_W'(r_beat) & c_LINE_MASK);
    assign w_last_beat  = (r_beat == c_BEAT_LAST);
    assign w_ram_we     = (r_state == c_ST_WRITE);
    assign w_ram_re     = (r_state == c_ST_READ);
    assign w_data_state = (r_rw == c_SYS_RD) ? c_ST_READ : c_ST_WRITE;

    // Burst sequencer: strobe capture, wait states, beat counting, flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_base     <= '0;
            r_rw       <= c_SYS_RD;
            r_beat     <= '0;
            r_wait_cnt <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    if (sysstrobe) begin
                        r_base     <= sysaddress & ~c_LINE_MASK;
                        r_rw       <= sysrw;
                        r_beat     <= '0;
                        r_wait_cnt <= '0;
                        if (WAIT_STATES > 0) begin
                            r_state <= c_ST_WAIT;
                        end else begin
                            r_state <= (sysrw == c_SYS_RD) ? c_ST_READ : c_ST_WRITE;
                        end
                    end
                end
                c_ST_WAIT: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b1;
                    if (r_wait_cnt == c_WAIT_END) begin
                        r_wait_cnt <= '0;
                        r_state    <= w_data_state;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                c_ST_READ, c_ST_WRITE: begin
                    r_valid <= (r_state == c_ST_READ);
                    r_busy  <= 1'b1;
                    if (w_last_beat) begin
                        r_beat  <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    sys_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_addr),
        .i_wdata (sysdata_in),
        .o_rdata (sysdata_out)
    );

    assign sysvalid = r_valid;
    assign sysbusy  = r_busy;

`ifdef SYS_BYTE_MEMORY_STATS_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    // Count bursts whose final beat completes; a reset before then drops it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= 16'h0000;
            r_wr_cnt <= 16'h0000;
        end else if (w_last_beat) begin
            if (r_state == c_ST_READ) begin
                r_rd_cnt <= r_rd_cnt + 16'h0001;
            end
            if (r_state == c_ST_WRITE) begin
                r_wr_cnt <= r_wr_cnt + 16'h0001;
            end
        end
    end

    assign rd_burst_cnt = r_rd_cnt;
    assign wr_burst_cnt = r_wr_cnt;
`endif

endmodule : sys_byte_memory
`default_nettype wire

// File: tb/tb_sys_byte_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_byte_memory
// Description : Directed self-checking bench for sys_byte_memory. A second
//               instance with WAIT_STATES=2 covers the wait-state timing.
//               Honours SYS_BYTE_MEMORY_STATS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_byte_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sysaddress = '0;
    logic        sysrw = 1'b1;
    logic        sysstrobe = 1'b0;
    logic [7:0]  sysdata_in = '0;
    logic [7:0]  sysdata_out;
    logic        sysvalid;
    logic        sysbusy;

    logic [15:0] w_addr = '0;
    logic        w_rw = 1'b1;
    logic        w_strobe = 1'b0;
    logic [7:0]  w_din = '0;
    logic [7:0]  w_dout;
    logic        w_valid;
    logic        w_busy;

    int total = 0;
    int bad   = 0;
    int rd_exp = 0;
    int wr_exp = 0;

`ifdef SYS_BYTE_MEMORY_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, w_rd_cnt, w_wr_cnt;
`endif

    always #5 clk = ~clk;

    sys_byte_memory #(.ADDR_W(16), .BURST_LEN(4), .WAIT_STATES(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .sysaddress  (sysaddress),
        .sysrw       (sysrw),
        .sysstrobe   (sysstrobe),
        .sysdata_in  (sysdata_in),
        .sysdata_out (sysdata_out),
        .sysvalid    (sysvalid),
        .sysbusy     (sysbusy)
`ifdef SYS_BYTE_MEMORY_STATS_EN
        ,
        .rd_burst_cnt (rd_cnt),
        .wr_burst_cnt (wr_cnt)
`endif
    );

    sys_byte_memory #(.ADDR_W(16), .BURST_LEN(4), .WAIT_STATES(2)) dut_w (
        .clk         (clk),
        .reset       (reset),
        .sysaddress  (w_addr),
        .sysrw       (w_rw),
        .sysstrobe   (w_strobe),
        .sysdata_in  (w_din),
        .sysdata_out (w_dout),
        .sysvalid    (w_valid),
        .sysbusy     (w_busy)
`ifdef SYS_BYTE_MEMORY_STATS_EN
        ,
        .rd_burst_cnt (w_rd_cnt),
        .wr_burst_cnt (w_wr_cnt)
`endif
    );

    // Write burst on the main instance; bytes packed low byte first
    task automatic write_burst(input logic [15:0] addr, input logic [31:0] data,
                               output logic [4:0] bmask, output logic vany);
        bmask = '0;
        vany  = 1'b0;
        @(negedge clk);
        sysstrobe = 1'b1; sysrw = 1'b0; sysaddress = addr;
        @(posedge clk); #1;
        bmask[0] = sysbusy; vany = vany | sysvalid;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sysstrobe  = 1'b0;
            sysdata_in = data[8*i +: 8];
            @(posedge clk); #1;
            bmask[i+1] = sysbusy; vany = vany | sysvalid;
        end
        @(negedge clk);
        sysdata_in = 8'h00;
        wr_exp++;
    endtask

    // Read burst on the main instance, optionally injecting a strobe at edge N+inj_edge
    task automatic read_burst(input logic [15:0] addr, input int inj_edge, input logic [15:0] inj_addr,
                              output logic [31:0] data, output logic [8:0] vmask,
                              output logic [8:0] bmask, output int nval);
        data = '0; vmask = '0; bmask = '0; nval = 0;
        @(negedge clk);
        sysstrobe = 1'b1; sysrw = 1'b1; sysaddress = addr;
        @(posedge clk); #1;
        vmask[0] = sysvalid; bmask[0] = sysbusy;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            sysstrobe = (i == inj_edge);
            if (i == inj_edge) sysaddress = inj_addr;
            @(posedge clk); #1;
            vmask[i] = sysvalid; bmask[i] = sysbusy;
            if (sysvalid) begin
                if (nval < 4) data[8*nval +: 8] = sysdata_out;
                nval++;
            end
        end
        rd_exp++;
    endtask

    task automatic test_reset();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        total++; if (sysdata_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", sysdata_out); end
        total++; if (sysvalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sysvalid); end
        total++; if (sysbusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", sysbusy); end
        total++; if (w_busy !== 1'b0) begin bad++; $display("FAIL reset_wbusy got=%b exp=0", w_busy); end
        @(negedge clk); reset = 1'b0;
        rd_exp = 0; wr_exp = 0;
    endtask

    task automatic test_read_basic();
        logic [31:0] d; logic [8:0] vm, bm; int n; logic [4:0] wb; logic va;
        write_burst(16'h1234, 32'hD4C3B2A1, wb, va);
        read_burst(16'h1236, 0, 16'h0000, d, vm, bm, n);
        total++; if (d !== 32'hD4C3B2A1) begin bad++; $display("FAIL rd_data got=%h exp=D4C3B2A1", d); end
        total++; if (vm !== 9'h01E) begin bad++; $display("FAIL rd_valid_mask got=%b exp=000011110", vm); end
        total++; if (bm !== 9'h01E) begin bad++; $display("FAIL rd_busy_mask got=%b exp=000011110", bm); end
        total++; if (sysdata_out !== 8'hD4) begin bad++; $display("FAIL rd_hold got=%h exp=D4", sysdata_out); end
    endtask

    task automatic test_write();
        logic [31:0] d; logic [8:0] vm, bm; int n; logic [4:0] wb; logic va;
        write_burst(16'h003C, 32'hE3E2E1E0, wb, va);
        write_burst(16'h0044, 32'hF3F2F1F0, wb, va);
        write_burst(16'h0040, 32'h44332211, wb, va);
        total++; if (wb !== 5'b11110) begin bad++; $display("FAIL wr_busy_mask got=%b exp=11110", wb); end
        total++; if (va !== 1'b0) begin bad++; $display("FAIL wr_valid got=%b exp=0", va); end
        read_burst(16'h0040, 0, 16'h0000, d, vm, bm, n);
        total++; if (d !== 32'h44332211) begin bad++; $display("FAIL wr_readback got=%h exp=44332211", d); end
        read_burst(16'h003C, 0, 16'h0000, d, vm, bm, n);
        total++; if (d !== 32'hE3E2E1E0) begin bad++; $display("FAIL wr_below got=%h exp=E3E2E1E0", d); end
        read_burst(16'h0044, 0, 16'h0000, d, vm, bm, n);
        total++; if (d !== 32'hF3F2F1F0) begin bad++; $display("FAIL wr_above got=%h exp=F3F2F1F0", d); end
    endtask

    task automatic test_boundary();
        logic [31:0] d; logic [8:0] vm, bm; int n; logic [4:0] wb; logic va;
        write_burst(16'h0000, 32'h04030201, wb, va);
        write_burst(16'hFFFC, 32'h9F9E9D9C, wb, va);
        read_burst(16'hFFFD, 0, 16'h0000, d, vm, bm, n);
        total++; if (d !== 32'h9F9E9D9C) begin bad++; $display("FAIL top_line got=%h exp=9F9E9D9C", d); end
        read_burst(16'h0003, 0, 16'h0000, d, vm, bm, n);
        total++; if (d !== 32'h04030201) begin bad++; $display("FAIL zero_line got=%h exp=04030201", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [8:0] vm, bm; int n;
        read_burst(16'h1235, 2, 16'h0040, d, vm, bm, n);
        total++; if (d !== 32'hD4C3B2A1) begin bad++; $display("FAIL b2b_data got=%h exp=D4C3B2A1", d); end
        total++; if (vm !== 9'h01E) begin bad++; $display("FAIL b2b_valid_mask got=%b exp=000011110", vm); end
        total++; if (n !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", n); end
        read_burst(16'h0041, 0, 16'h0000, d, vm, bm, n);
        total++; if (d !== 32'h44332211) begin bad++; $display("FAIL b2b_next got=%h exp=44332211", d); end
        total++; if (vm !== 9'h01E) begin bad++; $display("FAIL b2b_next_mask got=%b exp=000011110", vm); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d; logic [8:0] vm, bm; int n; logic [4:0] wb; logic va;
        write_burst(16'h0100, 32'hA3A2A1A0, wb, va);
        @(negedge clk); sysstrobe = 1'b1; sysrw = 1'b0; sysaddress = 16'h0100;
        @(posedge clk);
        @(negedge clk); sysstrobe = 1'b0; sysdata_in = 8'h55;
        @(posedge clk);
        @(negedge clk); sysdata_in = 8'h66; reset = 1'b1;
        @(posedge clk); #1;
        total++; if (sysvalid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", sysvalid); end
        total++; if (sysbusy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", sysbusy); end
        total++; if (sysdata_out !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h exp=00", sysdata_out); end
        @(negedge clk); reset = 1'b0; sysdata_in = 8'h77;
        rd_exp = 0; wr_exp = 0;
        @(posedge clk);
        @(negedge clk); sysdata_in = 8'h88;
        @(posedge clk); #1;
        total++; if (sysbusy !== 1'b0) begin bad++; $display("FAIL rst_after_busy got=%b exp=0", sysbusy); end
        @(negedge clk); sysdata_in = 8'h00;
        read_burst(16'h0100, 0, 16'h0000, d, vm, bm, n);
        total++; if (d !== 32'hA3A26655) begin bad++; $display("FAIL rst_partial got=%h exp=A3A26655", d); end
    endtask

    task automatic test_stats();
`ifdef SYS_BYTE_MEMORY_STATS_EN
        logic [31:0] d; logic [8:0] vm, bm; int n; logic [4:0] wb; logic va;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        total++; if (rd_cnt !== 16'd0) begin bad++; $display("FAIL stats_rd_clr got=%0d exp=0", rd_cnt); end
        @(negedge clk); reset = 1'b0;
        rd_exp = 0; wr_exp = 0;
        write_burst(16'h0200, 32'h0D0C0B0A, wb, va);
        read_burst(16'h0200, 0, 16'h0000, d, vm, bm, n);
        read_burst(16'h0201, 0, 16'h0000, d, vm, bm, n);
        total++; if (rd_cnt !== 16'(rd_exp)) begin bad++; $display("FAIL stats_rd got=%0d exp=%0d", rd_cnt, rd_exp); end
        total++; if (wr_cnt !== 16'(wr_exp)) begin bad++; $display("FAIL stats_wr got=%0d exp=%0d", wr_cnt, wr_exp); end
`endif
    endtask

    task automatic test_wait_states();
        logic [31:0] wdat; logic [31:0] d; logic [8:0] vm, bm; int n;
        wdat = 32'h8D7C6B5A; d = '0; vm = '0; bm = '0; n = 0;
        @(negedge clk); w_strobe = 1'b1; w_rw = 1'b0; w_addr = 16'h2000;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            w_strobe = 1'b0;
            if (i >= 3 && i <= 6) w_din = wdat[8*(i-3) +: 8];
            else w_din = 8'h00;
            @(posedge clk);
        end
        @(negedge clk); w_strobe = 1'b1; w_rw = 1'b1; w_addr = 16'h2002;
        @(posedge clk); #1;
        vm[0] = w_valid; bm[0] = w_busy;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); w_strobe = 1'b0;
            @(posedge clk); #1;
            vm[i] = w_valid; bm[i] = w_busy;
            if (w_valid) begin
                if (n < 4) d[8*n +: 8] = w_dout;
                n++;
            end
        end
        total++; if (vm !== 9'h078) begin bad++; $display("FAIL ws_valid_mask got=%b exp=001111000", vm); end
        total++; if (bm !== 9'h07E) begin bad++; $display("FAIL ws_busy_mask got=%b exp=001111110", bm); end
        total++; if (d !== 32'h8D7C6B5A) begin bad++; $display("FAIL ws_data got=%h exp=8D7C6B5A", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write();
        test_boundary();
        test_back_to_back();
        test_reset_mid_write();
        test_stats();
        test_wait_states();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sys_byte_memory
`default_nettype wire
